position_bram_writer: RTL and testbench

POSITION_BRAM_WRITER -- requirements
Module: position_bram_writer

---
 rtl/position_bram_writer_if.sv | 37 +++
 rtl/position_bram_writer.sv | 164 ++++++++++++++++
 tb/tb_position_bram_writer.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/position_bram_writer_if.sv
`default_nettype none
// ============================================================================
//  Module      : position_bram_writer_if
//  Description : Update-stream bundle feeding the cell position BRAM writer.
//                A source (master) presents one particle beat per handshake;
//                the writer (slave) signals when it can consume a beat.
//                  in_valid : beat fields are valid
//                  in_data  : bit 96 = null flag, bits [95:0] = position
//                  in_cell  : destination cell of the beat
//                  in_last  : final beat of the update stream
//                  in_ready : writer accepts a beat this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
interface position_bram_writer_if;
    logic        in_valid;
    logic [96:0] in_data;
    logic [7:0]  in_cell;
    logic        in_last;
    logic        in_ready;

    modport master (
        output in_valid,
        output in_data,
        output in_cell,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_cell,
        input  in_last,
        output in_ready
    );
endinterface
`default_nettype wire

// File: rtl/position_bram_writer.sv
`default_nettype none
// ============================================================================
//  Module      : position_bram_writer
//  Description : Collects particle positions addressed to this node's cell
//                and writes them into the idle half of a double-buffered
//                position BRAM, closing each phase with a null terminator.
//  Ports       : clk, reset (async, active low)
//                Cell          - this node's cell id (bits [7:0] used)
//                double_buffer - half currently read; writer uses the other
//                start / abort - open / cancel a write phase
//                in_if         - update stream (slave side)
//                bram_we/bram_addr/bram_wdata - registered BRAM write port
//                count    - particles written this phase
//                done     - phase complete, terminator written
//                overflow - sticky, a matching particle was dropped
//  Revision    : 1.0 - initial release
// ============================================================================
module position_bram_writer #(
    parameter int DBSIZE = 256
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic [31:0]        Cell,
    input  wire logic               double_buffer,
    input  wire logic               start,
    input  wire logic               abort,
    position_bram_writer_if.slave   in_if,
    output logic                    bram_we,
    output logic [31:0]             bram_addr,
    output logic [96:0]             bram_wdata,
    output logic [8:0]              count,
    output logic                    done,
    output logic                    overflow
);

    localparam logic [31:0] c_DBSIZE    = 32'(DBSIZE);
    // Last slot of a half is reserved for the terminator.
    localparam logic [31:0] c_LAST_SLOT = 32'(DBSIZE - 1);
    localparam logic [8:0]  c_COUNT_MAX = 9'(DBSIZE - 1);
    localparam logic [96:0] c_TERM_WORD = {1'b1, 96'b0};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_TERM   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t      r_state,    w_state_nxt;
    logic [31:0] r_base,     w_base_nxt;
    logic [31:0] r_waddr,    w_waddr_nxt;
    logic [8:0]  r_count,    w_count_nxt;
    logic        r_done,     w_done_nxt;
    logic        r_overflow, w_overflow_nxt;
    logic        r_we,       w_we_nxt;
    logic [31:0] r_addr,     w_addr_nxt;
    logic [96:0] r_wdata,    w_wdata_nxt;

    logic w_handshake;
    logic w_match;
    logic w_unused_cell_hi;

    // Only the low byte of the cell id identifies the destination.
    assign w_unused_cell_hi = ^Cell[31:8];

    assign in_if.in_ready = (r_state == ST_ACCEPT);
    assign w_handshake    = in_if.in_valid && (r_state == ST_ACCEPT);
    assign w_match        = (in_if.in_cell == Cell[7:0]) && !in_if.in_data[96];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_base     <= 32'd0;
            r_waddr    <= 32'd0;
            r_count    <= 9'd0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= 32'd0;
            r_wdata    <= c_TERM_WORD;
        end else begin
            r_state    <= w_state_nxt;
            r_base     <= w_base_nxt;
            r_waddr    <= w_waddr_nxt;
            r_count    <= w_count_nxt;
            r_done     <= w_done_nxt;
            r_overflow <= w_overflow_nxt;
            r_we       <= w_we_nxt;
            r_addr     <= w_addr_nxt;
            r_wdata    <= w_wdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_base_nxt     = r_base;
        w_waddr_nxt    = r_waddr;
        w_count_nxt    = r_count;
        w_done_nxt     = r_done;
        w_overflow_nxt = r_overflow;
        w_we_nxt       = 1'b0;
        w_addr_nxt     = r_addr;
        w_wdata_nxt    = r_wdata;

        if (abort) begin
            // Cancel wins over everything; counters are left for inspection.
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        // Target the half the ring is not reading.
                        w_base_nxt     = double_buffer ? 32'd0 : c_DBSIZE;
                        w_waddr_nxt    = 32'd0;
                        w_count_nxt    = 9'd0;
                        w_overflow_nxt = 1'b0;
                        w_done_nxt     = 1'b0;
                        w_state_nxt    = ST_ACCEPT;
                    end
                end
                ST_ACCEPT: begin
                    if (w_handshake) begin
                        if (w_match) begin
                            if (r_waddr < c_LAST_SLOT) begin
                                w_we_nxt    = 1'b1;
                                w_addr_nxt  = r_base + r_waddr;
                                w_wdata_nxt = in_if.in_data;
                                w_waddr_nxt = r_waddr + 32'd1;
                                if (r_count != c_COUNT_MAX) begin
                                    w_count_nxt = r_count + 9'd1;
                                end
                            end else begin
                                w_overflow_nxt = 1'b1;
                            end
                        end
                        if (in_if.in_last) begin
                            w_state_nxt = ST_TERM;
                        end
                    end
                end
                ST_TERM: begin
                    w_we_nxt    = 1'b1;
                    w_addr_nxt  = r_base + r_waddr;
                    w_wdata_nxt = c_TERM_WORD;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_DONE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign bram_we    = r_we;
    assign bram_addr  = r_addr;
    assign bram_wdata = r_wdata;
    assign count      = r_count;
    assign done       = r_done;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_position_bram_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_position_bram_writer
//  Description : Scoreboard bench for position_bram_writer. Expected BRAM
//                writes are queued by a reference model when beats are
//                issued; a monitor pops and compares on every write.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_position_bram_writer;

    localparam int          DBSIZE = 256;
    localparam logic [96:0] TERM_W = {1'b1, 96'b0};

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Cell;
    logic        double_buffer;
    logic        start;
    logic        abort;
    logic        bram_we;
    logic [31:0] bram_addr;
    logic [96:0] bram_wdata;
    logic [8:0]  count;
    logic        done;
    logic        overflow;

    position_bram_writer_if bus();

    position_bram_writer #(.DBSIZE(DBSIZE)) dut (
        .clk           (clk),
        .reset         (reset),
        .Cell          (Cell),
        .double_buffer (double_buffer),
        .start         (start),
        .abort         (abort),
        .in_if         (bus),
        .bram_we       (bram_we),
        .bram_addr     (bram_addr),
        .bram_wdata    (bram_wdata),
        .count         (count),
        .done          (done),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Expected writes as {addr, data}.
    logic [128:0] exp_q[$];

    // Reference model: a phase fills slots 0..DBSIZE-2 of the chosen half.
    bit          m_active = 0;
    logic [31:0] m_base   = 0;
    int          m_written = 0;
    bit          m_ovf    = 0;

    task automatic check(input string name, input logic [128:0] act, input logic [128:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_start(input logic db);
        if (!m_active) begin
            m_active  = 1;
            m_base    = db ? 32'd0 : 32'(DBSIZE);
            m_written = 0;
            m_ovf     = 0;
        end
    endtask

    task automatic model_beat(input logic [96:0] d, input logic [7:0] c, input bit last);
        if (c == Cell[7:0] && !d[96]) begin
            if (m_written < DBSIZE - 1) begin
                exp_q.push_back({m_base + 32'(m_written), d});
                m_written++;
            end else begin
                m_ovf = 1;
            end
        end
        if (last) begin
            exp_q.push_back({m_base + 32'(m_written), TERM_W});
            m_active = 0;
        end
    endtask

    // Monitor: every write the DUT issues must be the next expected one.
    always @(negedge clk) begin
        logic [128:0] e;
        if (reset === 1'b1 && bram_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: got addr %0h data %0h, expected no write",
                         bram_addr, bram_wdata);
            end else begin
                e = exp_q.pop_front();
                check("bram_write", {bram_addr, bram_wdata}, e);
            end
        end
    end

    // All driver tasks begin and end just after a falling edge.
    task automatic do_start(input logic db);
        double_buffer = db;
        start = 1'b1;
        model_start(db);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [96:0] d, input logic [7:0] c, input bit last);
        int guard;
        guard = 0;
        while (bus.in_ready !== 1'b1) begin
            if (guard == 50) begin
                n_cmp++;
                n_err++;
                $display("FAIL ready_timeout: in_ready got %b, expected 1", bus.in_ready);
                return;
            end
            guard++;
            @(negedge clk);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_cell  = c;
        bus.in_last  = last;
        model_beat(d, c, last);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_count, input bit exp_ovf);
        int guard;
        guard = 0;
        while (done !== 1'b1) begin
            if (guard == 20) begin
                n_cmp++;
                n_err++;
                $display("FAIL %s_done_timeout: done got %b, expected 1", name, done);
                break;
            end
            guard++;
            @(negedge clk);
        end
        @(negedge clk);
        check({name, "_done"},     done,          1);
        check({name, "_count"},    count,         exp_count);
        check({name, "_overflow"}, overflow,      exp_ovf);
        check({name, "_ready"},    bus.in_ready,  0);
        check({name, "_pending"},  exp_q.size(),  0);
    endtask

    function automatic logic [96:0] rand_pos(input bit null_flag);
        return {null_flag, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_reset_values(input string name);
        check({name, "_we"},       bram_we,      0);
        check({name, "_ready"},    bus.in_ready, 0);
        check({name, "_addr"},     bram_addr,    0);
        check({name, "_wdata"},    bram_wdata,   TERM_W);
        check({name, "_count"},    count,        0);
        check({name, "_done"},     done,         0);
        check({name, "_overflow"}, overflow,     0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int nb;
        reset         = 1'b0;
        Cell          = 32'd5;
        double_buffer = 1'b0;
        start         = 1'b0;
        abort         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_cell   = '0;
        bus.in_last   = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b1;
        @(negedge clk);
        check_reset_values("post_reset");

        // Three matching beats into the upper half.
        do_start(1'b0);
        for (int i = 0; i < 3; i++) send_beat(rand_pos(0), 8'd5, i == 2);
        wait_done("basic", 3, 0);

        // Non-matching beat is consumed but not written.
        do_start(1'b1);
        send_beat(rand_pos(0), 8'd5, 0);
        send_beat(rand_pos(0), 8'd7, 0);
        send_beat(rand_pos(0), 8'd5, 1);
        wait_done("filter", 2, 0);

        // Overflow: the last slot stays reserved for the terminator.
        do_start(1'b0);
        for (int i = 0; i < 300; i++) send_beat(rand_pos(0), 8'd5, i == 299);
        wait_done("overflow", 255, 1);

        // A lone null beat still produces a terminator at the base.
        do_start(1'($urandom_range(0, 1)));
        send_beat(rand_pos(1), 8'd5, 1);
        wait_done("null_only", 0, 0);

        // Abort after two writes: no terminator, then a fresh phase.
        do_start(1'b0);
        send_beat(rand_pos(0), 8'd5, 0);
        send_beat(rand_pos(0), 8'd5, 0);
        @(negedge clk);
        abort = 1'b1;
        m_active = 0;
        @(negedge clk);
        abort = 1'b0;
        check("abort_ready", bus.in_ready, 0);
        check("abort_done",  done,         0);
        check("abort_count", count,        2);
        repeat (3) @(negedge clk);
        do_start(1'b0);
        check("restart_count", count, 0);
        send_beat(rand_pos(0), 8'd5, 1);
        wait_done("restart", 1, 0);

        // Randomized phases with mixed cells, nulls, gaps, buffer toggles
        // and ignored mid-phase starts.
        for (int p = 0; p < 8; p++) begin
            Cell = $urandom;
            do_start(1'($urandom_range(0, 1)));
            nb = $urandom_range(1, 40);
            for (int b = 0; b < nb; b++) begin
                logic [7:0] c;
                repeat ($urandom_range(0, 2)) @(negedge clk);
                if ($urandom_range(0, 3) == 0) double_buffer = ~double_buffer;
                c = ($urandom_range(0, 2) != 0) ? Cell[7:0] : 8'($urandom);
                if ($urandom_range(0, 5) == 0) begin
                    start = 1'b1;
                    model_start(double_buffer);
                end
                send_beat(rand_pos($urandom_range(0, 4) == 0), c, b == nb - 1);
                start = 1'b0;
            end
            wait_done($sformatf("rand%0d", p), m_written, m_ovf);
        end

        // Asynchronous reset while a beat is being held valid.
        Cell = 32'd5;
        do_start(1'b0);
        send_beat(rand_pos(0), 8'd5, 0);
        bus.in_valid = 1'b1;
        bus.in_data  = rand_pos(0);
        bus.in_cell  = 8'd5;
        bus.in_last  = 1'b0;
        #2;
        reset = 1'b0;
        exp_q.delete();
        m_active = 0;
        #1;
        check_reset_values("mid_reset");
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("released_we%0d", i), bram_we, 0);
        end
        bus.in_valid = 1'b0;
        check("released_ready", bus.in_ready, 0);
        do_start(1'b1);
        send_beat(rand_pos(0), 8'd5, 1);
        wait_done("recover", 1, 0);

        check("final_pending", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
